// File: rtl/serial_mac_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_mac_unit_if
// Description : Operand/request and result signals of the serial MAC stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_mac_unit_if #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 20
);
   logic                 start;
   logic                 clear_acc;
   logic [WIDTH-1:0]     A_in;
   logic [WIDTH-1:0]     B_in;
   logic                 busy;
   logic                 done;
   logic [ACC_WIDTH-1:0] acc_out;
   logic                 overflow;

   modport master (
      output start, clear_acc, A_in, B_in,
      input  busy, done, acc_out, overflow
   );

   modport slave (
      input  start, clear_acc, A_in, B_in,
      output busy, done, acc_out, overflow
   );
endinterface
`default_nettype wire

// File: rtl/serial_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : serial_mac_unit
// Description : Shift-and-add multiplier (WIDTH cycles) feeding a wrapping
//               accumulator with a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mac_unit #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 20
) (
   input  wire logic        CLK,
   input  wire logic        CLR,
   serial_mac_unit_if.slave bus
);

   localparam int PROD_W = 2 * WIDTH;
   localparam int SUM_W  = ACC_WIDTH + 1;
   localparam int CNT_W  = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MULT  = 2'd1,
      S_ACCUM = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [PROD_W-1:0]    r_product;
   logic [PROD_W-1:0]    r_multiplicand;
   logic [WIDTH-1:0]     r_multiplier;
   logic [CNT_W-1:0]     r_count;
   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_overflow;
   logic [SUM_W-1:0]     w_sum;

   // One extra bit above the accumulator captures the wrap condition.
   assign w_sum = {1'b0, r_acc} + SUM_W'(r_product);

   always_ff @(posedge CLK) begin
      if (CLR) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next_state = S_MULT;
         S_MULT:  if (r_count == c_last_iter) w_next_state = S_ACCUM;
         S_ACCUM: w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         r_product      <= '0;
         r_multiplicand <= '0;
         r_multiplier   <= '0;
         r_count        <= '0;
         r_acc          <= '0;
         r_overflow     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Clear and start may coincide: the new product then lands on zero.
               if (bus.clear_acc) begin
                  r_acc      <= '0;
                  r_overflow <= 1'b0;
               end
               if (bus.start) begin
                  r_multiplicand <= PROD_W'(bus.A_in);
                  r_multiplier   <= bus.B_in;
                  r_product      <= '0;
                  r_count        <= '0;
               end
            end
            S_MULT: begin
               if (r_multiplier[0]) begin
                  r_product <= r_product + r_multiplicand;
               end
               r_multiplicand <= r_multiplicand << 1;
               r_multiplier   <= r_multiplier >> 1;
               r_count        <= r_count + 1'b1;
            end
            S_ACCUM: begin
               r_acc <= w_sum[ACC_WIDTH-1:0];
               if (w_sum[ACC_WIDTH]) begin
                  r_overflow <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy     = (r_state == S_MULT) || (r_state == S_ACCUM);
   assign bus.done     = (r_state == S_DONE);
   assign bus.acc_out  = r_acc;
   assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_mac_unit
// Description : Self-checking bench: vector table, corner sequences, random ops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_mac_unit;

   localparam int W  = 8;
   localparam int AW = 20;
   localparam longint ACC_MOD = 64'd1 << AW;

   logic CLK;
   logic CLR;

   serial_mac_unit_if #(.WIDTH(W), .ACC_WIDTH(AW)) bus ();

   serial_mac_unit #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
      .CLK (CLK),
      .CLR (CLR),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      bit         clr;
      logic [7:0] a;
      logic [7:0] b;
      longint     exp_acc;
      bit         exp_ovf;
   } vec_t;

   vec_t   vecs[$];
   int     n_pass  = 0;
   int     n_total = 0;
   longint m_acc   = 0;
   bit     m_ovf   = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
   endtask

   // Reference: exact integer sum, wrap modulo 2^AW, sticky wrap flag.
   task automatic model_step(input bit clr, input int a, input int b);
      longint s;
      if (clr) begin
         m_acc = 0;
         m_ovf = 1'b0;
      end
      s = m_acc + longint'(a) * longint'(b);
      if (s >= ACC_MOD) m_ovf = 1'b1;
      m_acc = s % ACC_MOD;
   endtask

   // Called at a negedge with the DUT idle.
   task automatic run_op(input string tag, input bit clr, input logic [7:0] a,
                         input logic [7:0] b, input longint exp_acc, input bit exp_ovf,
                         input bit interfere, input bit clr_in_done);
      bit ok;
      bus.start     = 1'b1;
      bus.clear_acc = clr;
      bus.A_in      = a;
      bus.B_in      = b;
      @(negedge CLK);
      bus.start     = 1'b0;
      bus.clear_acc = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < W + 1; i++) begin
         if (!(bus.busy === 1'b1 && bus.done === 1'b0)) ok = 1'b0;
         if (interfere && i == 2) begin
            bus.start     = 1'b1;
            bus.clear_acc = 1'b1;
            bus.A_in      = 8'd200;
            bus.B_in      = 8'd200;
         end else if (interfere && i == 3) begin
            bus.start     = 1'b0;
            bus.clear_acc = 1'b0;
            bus.A_in      = 8'd17;
            bus.B_in      = 8'd99;
         end
         @(negedge CLK);
      end
      check({tag, "_busy_window"}, longint'(ok), 1);
      check({tag, "_done"}, longint'(bus.done), 1);
      check({tag, "_busy_at_done"}, longint'(bus.busy), 0);
      check({tag, "_acc"}, longint'(bus.acc_out), exp_acc);
      check({tag, "_ovf"}, longint'(bus.overflow), longint'(exp_ovf));
      if (clr_in_done) bus.clear_acc = 1'b1;
      @(negedge CLK);
      bus.clear_acc = 1'b0;
      check({tag, "_done_one_cycle"}, longint'(bus.done), 0);
      check({tag, "_acc_held"}, longint'(bus.acc_out), exp_acc);
      if (interfere) begin
         ok = 1'b1;
         for (int i = 0; i < W + 3; i++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
            @(negedge CLK);
         end
         check({tag, "_no_second_op"}, longint'(ok), 1);
      end
   endtask

   initial begin
      bit ok;

      // Table: expected values are worked out by hand from the arithmetic.
      vecs.push_back('{1'b1, 8'd13,  8'd11,  143,     1'b0});
      for (int i = 1; i <= 16; i++)
         vecs.push_back('{(i == 1), 8'd255, 8'd255, 65025 * i, 1'b0});
      vecs.push_back('{1'b0, 8'd255, 8'd255, 56849,   1'b1});
      vecs.push_back('{1'b0, 8'd0,   8'd37,  56849,   1'b1});
      vecs.push_back('{1'b1, 8'd20,  8'd25,  500,     1'b0});
      vecs.push_back('{1'b1, 8'd3,   8'd4,   12,      1'b0});
      vecs.push_back('{1'b0, 8'd255, 8'd1,   267,     1'b0});
      vecs.push_back('{1'b1, 8'd7,   8'd11,  77,      1'b0});

      bus.start = 1'b0; bus.clear_acc = 1'b0; bus.A_in = '0; bus.B_in = '0;
      CLR = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      CLR = 1'b0;
      check("reset_busy", longint'(bus.busy), 0);
      check("reset_done", longint'(bus.done), 0);
      check("reset_acc", longint'(bus.acc_out), 0);
      check("reset_ovf", longint'(bus.overflow), 0);

      // Abort a running multiply with a two-edge reset.
      run_op("pre_abort", 1'b0, 8'd9, 8'd9, 81, 1'b0, 1'b0, 1'b0);
      bus.start = 1'b1; bus.A_in = 8'd13; bus.B_in = 8'd11;
      @(negedge CLK);
      bus.start = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      CLR = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      CLR = 1'b0;
      check("abort_busy", longint'(bus.busy), 0);
      check("abort_done", longint'(bus.done), 0);
      check("abort_acc", longint'(bus.acc_out), 0);
      check("abort_ovf", longint'(bus.overflow), 0);
      ok = 1'b1;
      for (int i = 0; i < W + 4; i++) begin
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
         @(negedge CLK);
      end
      check("abort_no_done", longint'(ok), 1);
      m_acc = 0; m_ovf = 1'b0;

      foreach (vecs[i]) begin
         model_step(vecs[i].clr, int'(vecs[i].a), int'(vecs[i].b));
         run_op($sformatf("vec%0d", i), vecs[i].clr, vecs[i].a, vecs[i].b,
                vecs[i].exp_acc, vecs[i].exp_ovf, 1'b0, 1'b0);
      end

      // Zero multiplicand keeps latency; clear_acc during DONE is ignored.
      model_step(1'b0, 0, 200);
      run_op("zero_a", 1'b0, 8'd0, 8'd200, m_acc, m_ovf, 1'b0, 1'b1);
      check("zero_a_clear_ignored", longint'(bus.acc_out), 77);

      // Requests and operand changes while busy are ignored.
      model_step(1'b0, 5, 6);
      run_op("interfere", 1'b0, 8'd5, 8'd6, m_acc, m_ovf, 1'b1, 1'b0);

      for (int n = 0; n < 60; n++) begin
         logic [7:0] ra, rb;
         bit rc;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rc = ($urandom_range(0, 9) == 0);
         model_step(rc, int'(ra), int'(rb));
         run_op($sformatf("rnd%0d", n), rc, ra, rb, m_acc, m_ovf, (n % 15 == 7), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: actual=running required=finished");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/serial_mac_unit.md
Name: serial_mac_unit

Overview:
Sequential shift-and-add multiply-accumulate stage that consumes the registered operand bits produced by the S-module register stage. It accepts two unsigned operands on a start pulse, multiplies them over WIDTH clock cycles, adds the product into a running accumulator, and signals completion with a one-cycle done pulse. The accumulator feeds the downstream result/readout logic of the MAC.

Parameters:
WIDTH, 8, operand width in bits (A_in, B_in); also the number of multiply iterations.
ACC_WIDTH, 20, accumulator width in bits; must be >= 2*WIDTH.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
CLR  input  1  synchronous, active-high reset.
start  input  1  request a multiply-accumulate; sampled only in IDLE.
clear_acc  input  1  zero the accumulator and overflow flag; sampled only in IDLE.
A_in  input  WIDTH  multiplicand, unsigned; sampled on the accepting edge only.
B_in  input  WIDTH  multiplier, unsigned; sampled on the accepting edge only.
busy  output  1  high in MULT and ACCUM states.
done  output  1  one-cycle pulse, high in DONE state.
acc_out  output  ACC_WIDTH  registered accumulator value.
overflow  output  1  sticky flag: set when any accumulate wraps past 2^ACC_WIDTH.

Behaviour:
- Reset: one clock, CLK; reset CLR is synchronous and active-high. With CLR high at a rising edge: state=IDLE, acc_out=0, overflow=0, busy=0, done=0, and internal product/multiplicand/multiplier/iteration counter all 0. CLR has priority over every other input and aborts any operation in progress; no done pulse follows an abort.
- FSM states: IDLE, MULT, ACCUM, DONE.
- IDLE: start=1 at edge k loads multiplicand register (2*WIDTH bits, zero-extended A_in) and multiplier register (B_in), clears product and counter, and moves to MULT. clear_acc=1 at the same edge zeroes acc_out and overflow. When both are high, both actions occur, so the new product accumulates into 0.
- MULT: edges k+1 .. k+WIDTH perform one iteration each: if multiplier LSB=1, product += multiplicand; multiplicand shifts left 1; multiplier shifts right 1; counter increments. After WIDTH iterations (edge k+WIDTH) state=ACCUM. No early termination on a zero multiplier; latency is fixed.
- ACCUM: edge k+WIDTH+1 sets acc_out <= (acc_out + zero-extended product) mod 2^ACC_WIDTH. If the true sum >= 2^ACC_WIDTH, overflow <= 1. Overflow is never cleared except by CLR or clear_acc. State then = DONE.
- DONE: done=1 for exactly one cycle, with acc_out already holding the updated value. Edge k+WIDTH+2 returns to IDLE.
- Total: done is high during the cycle after edge k+WIDTH+1. A new start is accepted no earlier than edge k+WIDTH+3.
- start and clear_acc are ignored in MULT, ACCUM and DONE; they are not queued. A_in/B_in changes after edge k have no effect.
- Arithmetic is unsigned throughout. The product is exact in 2*WIDTH bits.
- Outputs: busy and done decode from the state register (glitch-free, no combinational input paths). acc_out and overflow are direct register outputs.

Test Plan:
1. CLR=1 for 2 edges during a running MULT -> next cycle state IDLE, acc_out=0, overflow=0, busy=0, done=0; no done pulse follows.
2. After reset, start with A_in=13, B_in=11 -> busy=1 for 9 cycles, done=1 in the 10th cycle after the start edge, acc_out=143, overflow=0.
3. Repeat start with A_in=255, B_in=255 seventeen times with no clear -> after the 16th, acc_out=1040400, overflow=0; after the 17th, acc_out=56849 (1105425-1048576), overflow=1.
4. With acc_out=500, assert clear_acc and start together with A_in=3, B_in=4 -> acc_out=12, overflow=0 at done.
5. During busy, pulse start with A_in=200, B_in=200 and change A_in/B_in -> ignored; the original operation's result is unchanged; the FSM returns to IDLE with no second done.
6. Start with A_in=0, B_in=200 and with acc_out=77 -> done still pulses at the fixed latency, acc_out=77; clear_acc pulsed in DONE state has no effect.
